// File: rtl/reg_scoreboard_pkg.sv
// Shared constants and types for the register-hazard scoreboard.
// REGNOBITS must stay equal to the pipeline-wide define header value.
package reg_scoreboard_pkg;
    localparam int NREGS     = 32;
    localparam int REGNOBITS = 5;
    localparam int CNTBITS   = 2;
    localparam int WB_BYPASS = 1;

    typedef logic [CNTBITS-1:0]   cnt_t;
    typedef logic [REGNOBITS-1:0] regno_t;

    localparam cnt_t CNT_MAX = '1;
endpackage

// File: rtl/reg_scoreboard_counter.sv
// Per-register pending-writer counter: saturating up/down with zero/full flags.
// Simultaneous inc and dec cancel; a lone dec at zero holds and pulses underflow.
module sb_counter
    import reg_scoreboard_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic dec,
    output cnt_t cnt,
    output logic zero,
    output logic full,
    output logic underflow
);
    cnt_t cnt_q;
    cnt_t cnt_d;

    always_comb begin
        cnt_d     = cnt_q;
        underflow = 1'b0;
        if (inc && !dec) begin
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + cnt_t'(1);
        end else if (dec && !inc) begin
            if (cnt_q == '0) underflow = 1'b1;
            else             cnt_d = cnt_q - cnt_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);
    assign full = (cnt_q == CNT_MAX);
endmodule

// File: rtl/reg_scoreboard.sv
// Register-hazard scoreboard between decode and writeback: stalls issue on
// RAW hazards or a saturated destination counter, tracks in-flight writers.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 issue_valid,
    input  logic                 issue_wr_reg,
    input  logic [REGNOBITS-1:0] issue_rd,
    input  logic                 src1_used,
    input  logic [REGNOBITS-1:0] src1,
    input  logic                 src2_used,
    input  logic [REGNOBITS-1:0] src2,
    input  logic                 wb_wr_reg,
    input  logic [REGNOBITS-1:0] wb_regno,
    output logic                 stall,
    output logic                 issue_fire,
    output logic [NREGS-1:0]     busy_vec,
    output logic [7:0]           inflight_total,
    output logic                 underflow_err
);
    cnt_t             cnt_arr [NREGS];
    logic [NREGS-1:0] zero_vec, full_vec, uflow_vec, inc_vec, dec_vec;

    // x0 has no counter: it reads as empty and is never full.
    assign cnt_arr[0]   = '0;
    assign zero_vec[0]  = 1'b1;
    assign full_vec[0]  = 1'b0;
    assign uflow_vec[0] = 1'b0;

    for (genvar i = 1; i < NREGS; i++) begin : g_cnt
        sb_counter u_cnt (
            .clk       (clk),
            .reset     (reset),
            .inc       (inc_vec[i]),
            .dec       (dec_vec[i]),
            .cnt       (cnt_arr[i]),
            .zero      (zero_vec[i]),
            .full      (full_vec[i]),
            .underflow (uflow_vec[i])
        );
    end

    logic src1_haz, src2_haz, dst_haz, inc_any, dec_ok;

    always_comb begin
        src1_haz = src1_used && !zero_vec[src1];
        src2_haz = src2_used && !zero_vec[src2];
        // Regfile writes first half-cycle, so a last pending writer retiring now is readable.
        if (WB_BYPASS != 0) begin
            if (cnt_arr[src1] == cnt_t'(1) && wb_wr_reg && wb_regno == src1) src1_haz = 1'b0;
            if (cnt_arr[src2] == cnt_t'(1) && wb_wr_reg && wb_regno == src2) src2_haz = 1'b0;
        end
        dst_haz    = issue_wr_reg && full_vec[issue_rd];
        stall      = issue_valid && (src1_haz || src2_haz || dst_haz);
        issue_fire = issue_valid && !stall;

        inc_any = issue_fire && issue_wr_reg && (issue_rd != '0);
        inc_vec = '0;
        dec_vec = '0;
        if (inc_any) inc_vec[issue_rd] = 1'b1;
        if (wb_wr_reg && wb_regno != '0) dec_vec[wb_regno] = 1'b1;
        inc_vec[0] = 1'b0;
        dec_vec[0] = 1'b0;
        dec_ok     = |dec_vec && !(|uflow_vec);
    end

    logic [7:0] inflight_total_q, inflight_total_d;
    logic       underflow_err_q, underflow_err_d;

    always_comb begin
        inflight_total_d = inflight_total_q;
        if (inc_any && !dec_ok && inflight_total_q != 8'hff) inflight_total_d = inflight_total_q + 8'd1;
        else if (dec_ok && !inc_any && inflight_total_q != 8'h00) inflight_total_d = inflight_total_q - 8'd1;
        underflow_err_d = underflow_err_q || (|uflow_vec);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            inflight_total_q <= '0;
            underflow_err_q  <= 1'b0;
        end else begin
            inflight_total_q <= inflight_total_d;
            underflow_err_q  <= underflow_err_d;
        end
    end

    assign busy_vec       = ~zero_vec;
    assign inflight_total = inflight_total_q;
    assign underflow_err  = underflow_err_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: directed scenarios plus random traffic, all
// compared every cycle against a per-register count model.
module tb_reg_scoreboard;
    import reg_scoreboard_pkg::*;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 issue_valid, issue_wr_reg, src1_used, src2_used, wb_wr_reg;
    logic [REGNOBITS-1:0] issue_rd, src1, src2, wb_regno;
    logic                 stall, issue_fire, underflow_err;
    logic [NREGS-1:0]     busy_vec;
    logic [7:0]           inflight_total;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: pending writer count per register, sticky error.
    int m_cnt [NREGS];
    bit m_err;
    bit model_on = 1'b0;
    localparam int MAXC = (1 << CNTBITS) - 1;

    reg_scoreboard dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_wr_reg(issue_wr_reg), .issue_rd(issue_rd),
        .src1_used(src1_used), .src1(src1), .src2_used(src2_used), .src2(src2),
        .wb_wr_reg(wb_wr_reg), .wb_regno(wb_regno),
        .stall(stall), .issue_fire(issue_fire), .busy_vec(busy_vec),
        .inflight_total(inflight_total), .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit src_haz(bit used, int s);
        if (!used || s == 0 || m_cnt[s] == 0) return 1'b0;
        if (WB_BYPASS != 0 && m_cnt[s] == 1 && wb_wr_reg && int'(wb_regno) == s) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit model_stall();
        bit dst;
        dst = issue_wr_reg && issue_rd != 0 && m_cnt[issue_rd] == MAXC;
        return issue_valid && (src_haz(src1_used, src1) || src_haz(src2_used, src2) || dst);
    endfunction

    function automatic int model_total();
        int s = 0;
        for (int i = 1; i < NREGS; i++) s += m_cnt[i];
        return (s > 255) ? 255 : s;
    endfunction

    // Model advance at the active edge, from the inputs held across it.
    always @(posedge clk) begin
        bit inc, dec;
        if (reset) begin
            for (int i = 0; i < NREGS; i++) m_cnt[i] = 0;
            m_err    = 1'b0;
            model_on = 1'b1;
        end else if (model_on) begin
            inc = issue_valid && !model_stall() && issue_wr_reg && issue_rd != 0;
            dec = wb_wr_reg && wb_regno != 0;
            if (inc && dec && issue_rd == wb_regno) begin
                // a new writer and a retiring writer of the same register cancel
            end else begin
                if (dec) begin
                    if (m_cnt[wb_regno] == 0) m_err = 1'b1;
                    else m_cnt[wb_regno]--;
                end
                if (inc) m_cnt[issue_rd]++;
            end
        end
    end

    // Compare process, mid-cycle.
    always @(negedge clk) begin
        if (model_on && !reset) begin
            bit exp_st;
            logic [NREGS-1:0] exp_busy;
            exp_st = model_stall();
            for (int i = 0; i < NREGS; i++) exp_busy[i] = (m_cnt[i] != 0);
            check("stall", stall, exp_st);
            check("issue_fire", issue_fire, issue_valid && !exp_st);
            check("busy_vec", busy_vec, exp_busy);
            check("inflight_total", inflight_total, model_total());
            check("underflow_err", underflow_err, m_err);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input bit v, input bit w, input int rd, input bit u1, input int s1,
                       input bit u2, input int s2, input bit wbw, input int wbr);
        issue_valid = v; issue_wr_reg = w; issue_rd = regno_t'(rd);
        src1_used = u1; src1 = regno_t'(s1); src2_used = u2; src2 = regno_t'(s2);
        wb_wr_reg = wbw; wb_regno = regno_t'(wbr);
    endtask

    task automatic idle();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        idle();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        #1;
        check("reset busy", busy_vec, 0);
        check("reset total", inflight_total, 0);
        check("reset stall", stall, 0);
        check("reset err", underflow_err, 0);

        // RAW on x5 with writeback bypass
        drv(1, 1, 5, 0, 0, 0, 0, 0, 0); tick();
        drv(1, 0, 0, 1, 5, 0, 0, 0, 0); #1;
        check("raw stall", stall, 1);
        tick();
        check("raw stall hold", stall, 1);
        drv(1, 0, 0, 1, 5, 0, 0, 1, 5); #1;
        check("raw bypass stall", stall, 0);
        check("raw bypass fire", issue_fire, 1);
        tick(); idle(); #1;
        check("raw busy5", busy_vec[5], 0);

        // x0 immunity
        drv(1, 1, 0, 0, 0, 0, 0, 0, 0); tick();
        drv(1, 0, 0, 1, 0, 1, 0, 0, 0); #1;
        check("x0 stall", stall, 0);
        tick(); idle(); #1;
        check("x0 total", inflight_total, 0);

        // Saturation of x7
        drv(1, 1, 7, 0, 0, 0, 0, 0, 0); tick(); tick(); tick();
        #1;
        check("sat total", inflight_total, 3);
        check("sat stall", stall, 1);
        drv(1, 1, 7, 0, 0, 0, 0, 1, 7); #1;
        check("sat stall wb", stall, 1);
        tick();
        drv(1, 1, 7, 0, 0, 0, 0, 0, 0); #1;
        check("sat release", issue_fire, 1);
        tick(); idle(); #1;
        check("sat total again", inflight_total, 3);
        drv(0, 0, 0, 0, 0, 0, 0, 1, 7); tick(); tick(); tick(); idle(); #1;
        check("sat drained", inflight_total, 0);

        // Simultaneous inc/dec
        drv(1, 1, 9, 0, 0, 0, 0, 0, 0); tick();
        drv(1, 1, 9, 0, 0, 0, 0, 1, 9); tick(); idle(); #1;
        check("same busy9", busy_vec[9], 1);
        check("same total", inflight_total, 1);
        drv(1, 1, 4, 0, 0, 0, 0, 0, 0); tick();
        drv(1, 1, 9, 0, 0, 0, 0, 1, 4); tick(); idle(); #1;
        check("diff total", inflight_total, 2);
        check("diff busy4", busy_vec[4], 0);
        drv(0, 0, 0, 0, 0, 0, 0, 1, 9); tick(); tick(); idle(); #1;
        check("diff drained", inflight_total, 0);

        // Underflow then reset during an issue
        drv(0, 0, 0, 0, 0, 0, 0, 1, 12); tick(); idle(); #1;
        check("uflow err", underflow_err, 1);
        check("uflow busy12", busy_vec[12], 0);
        check("uflow total", inflight_total, 0);
        reset = 1'b1;
        drv(1, 1, 3, 0, 0, 0, 0, 0, 0); tick();
        reset = 1'b0; idle(); #1;
        check("rst busy3", busy_vec[3], 0);
        check("rst err", underflow_err, 0);

        // Random traffic on a small register window to provoke hazards
        for (int c = 0; c < 3000; c++) begin
            int wr;
            if (!stall || !issue_valid) begin
                issue_valid  = ($urandom_range(0, 3) != 0);
                issue_wr_reg = $urandom_range(0, 1);
                issue_rd     = regno_t'($urandom_range(0, 7));
                src1_used    = $urandom_range(0, 1);
                src1         = regno_t'($urandom_range(0, 7));
                src2_used    = $urandom_range(0, 1);
                src2         = regno_t'($urandom_range(0, 7));
            end
            wr = $urandom_range(1, 7);
            if (m_cnt[wr] != 0) begin
                wb_wr_reg = ($urandom_range(0, 2) != 0);
            end else begin
                wb_wr_reg = ($urandom_range(0, 199) == 0) && !(issue_wr_reg && int'(issue_rd) == wr);
            end
            wb_regno = regno_t'(wr);
            tick();
        end
        idle();
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
